// File: rtl/sr_cmd_debounce.sv
// ============================================================================
// Module   : sr_cmd_debounce
// Purpose  : Synchronizes and debounces two push-buttons and turns their press
//            edges into arbitrated, mutually exclusive one-cycle s/r pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_cmd_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_async_n,
  input  logic set_btn_raw,
  input  logic rst_btn_raw,
  output logic s,
  output logic r,
  output logic set_level,
  output logic rst_level,
  output logic conflict
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] c_last = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    QUAL_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    QUAL_LOW  = 2'd3
  } state_t;

  // bit 0 = set channel, bit 1 = reset channel
  logic [1:0] w_raw;
  logic [1:0] w_lvl;
  logic [1:0] w_lvl_nxt;

  assign w_raw = {rst_btn_raw, set_btn_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
        r_sync  <= '0;
        r_state <= IDLE_LOW;
        r_cnt   <= '0;
      end else begin
        r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw[ch]};
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // cnt holds the number of consecutive qualifying samples seen so far;
    // the transition completes on the DEBOUNCE_CYCLES-th one.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        IDLE_LOW: begin
          if (w_sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_state_nxt = IDLE_HIGH;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = QUAL_HIGH;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        QUAL_HIGH: begin
          if (!w_sync) begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_last) begin
            w_state_nxt = IDLE_HIGH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!w_sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_state_nxt = IDLE_LOW;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = QUAL_LOW;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        QUAL_LOW: begin
          if (w_sync) begin
            w_state_nxt = IDLE_HIGH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_last) begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // The debounced level is 1 exactly in the two "high side" states.
    assign w_lvl[ch]     = (r_state == IDLE_HIGH) || (r_state == QUAL_LOW);
    assign w_lvl_nxt[ch] = (w_state_nxt == IDLE_HIGH) || (w_state_nxt == QUAL_LOW);
  end

  logic w_set_press;
  logic w_rst_press;

  assign w_set_press = w_lvl_nxt[0] & ~w_lvl[0];
  assign w_rst_press = w_lvl_nxt[1] & ~w_lvl[1];

  // Reset always wins: a set press is swallowed whenever reset is (or is
  // becoming) active, which also covers both presses landing together.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= w_set_press & ~w_lvl_nxt[1];
      r        <= w_rst_press;
      conflict <= (w_set_press & w_lvl_nxt[1]) | (w_rst_press & w_lvl_nxt[0]);
    end
  end

  assign set_level = w_lvl[0];
  assign rst_level = w_lvl[1];

endmodule

`default_nettype wire
